// File: rtl/servo_pkg.sv
// Shared servo constants, sel codes and decoder state encoding.
package servo_pkg;

    localparam int unsigned DEF_TICK_DIV    = 5000;
    localparam int unsigned DEF_W0          = 10;
    localparam int unsigned DEF_W1          = 15;
    localparam int unsigned DEF_W2          = 20;
    localparam int unsigned DEF_TOL         = 2;
    localparam int unsigned DEF_MAX_HIGH    = 30;
    localparam int unsigned DEF_LOW_TIMEOUT = 250;

    // Codes follow the decoded width order: 1.0 ms, 1.5 ms, 2.0 ms.
    localparam logic [1:0] SEL_1MS   = 2'd0;
    localparam logic [1:0] SEL_1P5MS = 2'd1;
    localparam logic [1:0] SEL_2MS   = 2'd2;
    localparam logic [1:0] SEL_LOW   = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_LOW      = 2'd1,
        ST_HIGH     = 2'd2
    } dec_state_e;

    function automatic logic in_band(input logic [7:0] count,
                                     input int unsigned nom,
                                     input int unsigned tol);
        int unsigned c;
        c = {24'd0, count};
        return (c + tol >= nom) && (c <= nom + tol);
    endfunction

endpackage

// File: rtl/servo_pulse_decoder_tick_gen.sv
// Prescaler: one-clk tick every DIV clks, restartable by a sync clear.
module tick_gen #(
    parameter int unsigned DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == CW'(DIV - 1));
    assign tick = wrap;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo high pulses in ticks and decodes them to sel codes.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
    parameter int unsigned W0          = DEF_W0,
    parameter int unsigned W1          = DEF_W1,
    parameter int unsigned W2          = DEF_W2,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned MAX_HIGH    = DEF_MAX_HIGH,
    parameter int unsigned LOW_TIMEOUT = DEF_LOW_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pwm_in,
    output logic [1:0] sel,
    output logic [7:0] width,
    output logic       valid,
    output logic       err
);

    logic [1:0]  sync_q, sync_d;
    logic        pwm_d_q, pwm_d_d;
    logic        pwm_s, rise, fall, tick;

    dec_state_e  state_q, state_d;
    logic [15:0] low_q, low_d, low_inc;
    logic [7:0]  high_q, high_d, hi_inc;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  width_q, width_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    assign pwm_s = sync_q[1];
    assign rise  = pwm_s & ~pwm_d_q;
    assign fall  = ~pwm_s & pwm_d_q;

    assign sync_d  = {sync_q[0], pwm_in};
    assign pwm_d_d = pwm_s;

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (rise | fall),
        .tick (tick)
    );

    // A tick landing on the fall cycle still belongs to the pulse.
    always_comb begin
        hi_inc = high_q + {7'd0, tick};
        if (high_q == 8'hFF) begin
            hi_inc = 8'hFF;
        end
        low_inc = low_q + {15'd0, tick};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            pwm_d_q <= 1'b1;
            state_q <= ST_WAIT_LOW;
            low_q   <= '0;
            high_q  <= '0;
            sel_q   <= SEL_1MS;
            width_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pwm_d_q <= pwm_d_d;
            state_q <= state_d;
            low_q   <= low_d;
            high_q  <= high_d;
            sel_q   <= sel_d;
            width_q <= width_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_LOW: if (!pwm_s) state_d = ST_LOW;
            ST_LOW:      if (rise) state_d = ST_HIGH;
            ST_HIGH: begin
                if (fall) begin
                    state_d = ST_LOW;
                end else if (hi_inc >= 8'(MAX_HIGH)) begin
                    state_d = ST_WAIT_LOW;
                end
            end
            default:     state_d = ST_WAIT_LOW;
        endcase
    end

    always_comb begin
        low_d   = low_q;
        high_d  = high_q;
        sel_d   = sel_q;
        width_d = width_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_WAIT_LOW: begin
                low_d  = '0;
                high_d = '0;
            end
            ST_LOW: begin
                if (rise) begin
                    high_d = '0;
                end else if (low_inc == 16'(LOW_TIMEOUT)) begin
                    low_d   = '0;
                    valid_d = 1'b1;
                    sel_d   = SEL_LOW;
                    width_d = '0;
                end else begin
                    low_d = low_inc;
                end
            end
            ST_HIGH: begin
                high_d = hi_inc;
                if (fall) begin
                    low_d = '0;
                    if (in_band(hi_inc, W0, TOL)) begin
                        sel_d   = SEL_1MS;
                        width_d = hi_inc;
                        valid_d = 1'b1;
                    end else if (in_band(hi_inc, W1, TOL)) begin
                        sel_d   = SEL_1P5MS;
                        width_d = hi_inc;
                        valid_d = 1'b1;
                    end else if (in_band(hi_inc, W2, TOL)) begin
                        sel_d   = SEL_2MS;
                        width_d = hi_inc;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (hi_inc >= 8'(MAX_HIGH)) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                low_d  = '0;
                high_d = '0;
            end
        endcase
    end

    assign sel   = sel_q;
    assign width = width_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder with TICK_DIV = 10.
module tb_servo_pulse_decoder;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic [1:0] sel;
    logic [7:0] width;
    logic       valid;
    logic       err;

    int checks;
    int errors;
    int vcnt;
    int ecnt;
    int both;
    int v0;
    int e0;
    logic p_v2, p_v3, p_v4, p_e2, p_e3, p_e4;

    servo_pulse_decoder #(
        .TICK_DIV (10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .sel    (sel),
        .width  (width),
        .valid  (valid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            vcnt += int'(valid);
            ecnt += int'(err);
            both += int'(valid & err);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller is at posedge+1; captures strobes on edges 2..4 after the fall.
    task automatic pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        repeat (hi) @(posedge clk);
        #1 pwm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        p_v2 = valid;
        p_e2 = err;
        @(posedge clk);
        #1;
        p_v3 = valid;
        p_e3 = err;
        @(posedge clk);
        #1;
        p_v4 = valid;
        p_e4 = err;
        repeat (lo - 4) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vcnt   = 0;
        ecnt   = 0;
        both   = 0;
        pwm_in = 1'b0;
        rst    = 1'b1;
        idle(5);
        chk("rst_sel", int'(sel), 0);
        chk("rst_width", int'(width), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        idle(20);

        // 1.0 ms pulse with exact latency
        v0 = vcnt; e0 = ecnt;
        pulse(105, 1895);
        chk("t1_lat_e2", int'(p_v2), 0);
        chk("t1_lat_e3", int'(p_v3), 1);
        chk("t1_lat_e4", int'(p_v4), 0);
        chk("t1_sel", int'(sel), 0);
        chk("t1_width", int'(width), 10);
        chk("t1_nvalid", vcnt - v0, 1);
        chk("t1_nerr", ecnt - e0, 0);

        // 1.5 ms and 2.0 ms back-to-back frames
        v0 = vcnt; e0 = ecnt;
        pulse(155, 1845);
        chk("t2_sel15", int'(sel), 1);
        chk("t2_width15", int'(width), 15);
        pulse(205, 1795);
        chk("t2_sel20", int'(sel), 2);
        chk("t2_width20", int'(width), 20);
        chk("t2_nvalid", vcnt - v0, 2);
        chk("t2_nerr", ecnt - e0, 0);

        // out-of-band pulses
        v0 = vcnt; e0 = ecnt;
        pulse(255, 500);
        chk("t3_err_e2", int'(p_e2), 0);
        chk("t3_err_e3", int'(p_e3), 1);
        chk("t3_err_e4", int'(p_e4), 0);
        chk("t3_valid_e3", int'(p_v3), 0);
        chk("t3_sel", int'(sel), 2);
        chk("t3_width", int'(width), 20);
        pulse(65, 500);
        chk("t3_short_err", int'(p_e3), 1);
        chk("t3_short_width", int'(width), 20);
        chk("t3_nvalid", vcnt - v0, 0);
        chk("t3_nerr", ecnt - e0, 2);

        // line held low
        pulse(105, 100);
        chk("t4_pre_sel", int'(sel), 0);
        v0 = vcnt;
        idle(2500);
        chk("t4_to_n1", vcnt - v0, 1);
        chk("t4_to_sel", int'(sel), 3);
        chk("t4_to_width", int'(width), 0);
        idle(2500);
        chk("t4_to_n2", vcnt - v0, 2);
        pulse(105, 500);
        chk("t4_after_sel", int'(sel), 0);
        chk("t4_after_width", int'(width), 10);

        // reset released while line is high
        rst = 1'b1;
        pwm_in = 1'b1;
        idle(3);
        rst = 1'b0;
        v0 = vcnt; e0 = ecnt;
        idle(400);
        pwm_in = 1'b0;
        idle(200);
        chk("t5_quiet_v", vcnt - v0, 0);
        chk("t5_quiet_e", ecnt - e0, 0);
        pulse(300, 300);
        chk("t5_stuck_v", vcnt - v0, 0);
        chk("t5_stuck_e", ecnt - e0, 1);
        pulse(155, 500);
        chk("t5_next_sel", int'(sel), 1);

        // reset in the middle of a pulse
        pwm_in = 1'b1;
        idle(50);
        rst = 1'b1;
        #1;
        chk("t6_rst_sel", int'(sel), 0);
        chk("t6_rst_width", int'(width), 0);
        chk("t6_rst_valid", int'(valid), 0);
        idle(2);
        rst = 1'b0;
        v0 = vcnt; e0 = ecnt;
        idle(105);
        pwm_in = 1'b0;
        idle(300);
        chk("t6_tail_v", vcnt - v0, 0);
        chk("t6_tail_e", ecnt - e0, 0);
        pulse(205, 300);
        chk("t6_sel", int'(sel), 2);
        chk("t6_width", int'(width), 20);

        chk("excl_valid_err", both, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
